// File: rtl/diff_engine_scheduler.sv
// Round-robin scheduler that shares one difference engine among NUM_REQ requesters.
// Serves one requester at a time: capture argument, start the engine, wait with a timeout, deliver the result.
module diff_engine_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int N_WIDTH = 6,
    parameter int F_WIDTH = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*N_WIDTH-1:0] n_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [F_WIDTH-1:0]         result_o,
    output logic                       timeout_o,
    output logic                       busy_o,
    output logic                       eng_compute_o,
    output logic [N_WIDTH-1:0]         eng_n_o,
    input  logic                       eng_done_i,
    input  logic [F_WIDTH-1:0]         eng_f_i,
    output logic [1:0]                 state_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [F_WIDTH-1:0]   result_q, result_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic                 comp_q, comp_d;
    logic [N_WIDTH-1:0]   eng_n_q, eng_n_d;
    logic                 found;
    logic [IDX_W-1:0]     win;

    // req_i is a level held by the requester until it sees its grant_o bit; a bit
    // dropped earlier is simply never picked. grant_o marks the cycle the argument was taken.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_i[(int'(last_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDX_W'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        grant_d   = '0;
        done_d    = '0;
        result_d  = result_q;
        timeout_d = 1'b0;
        comp_d    = 1'b0;
        eng_n_d   = eng_n_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_ISSUE;
                    grant_d = NUM_REQ'(1) << win;
                    comp_d  = 1'b1;
                    eng_n_d = n_i[int'(win)*N_WIDTH +: N_WIDTH];
                    last_d  = win;
                    cur_d   = win;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A completion on the terminal-count cycle still wins over the abort.
                if (eng_done_i) begin
                    state_d  = S_DELIVER;
                    done_d   = NUM_REQ'(1) << cur_q;
                    result_d = eng_f_i;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_DELIVER;
                    done_d    = NUM_REQ'(1) << cur_q;
                    result_d  = '1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            cur_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            comp_q    <= 1'b0;
            eng_n_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            comp_q    <= comp_d;
            eng_n_q   <= eng_n_d;
        end
    end

    assign grant_o       = grant_q;
    assign done_o        = done_q;
    assign result_o      = result_q;
    assign timeout_o     = timeout_q;
    assign busy_o        = busy_q;
    assign eng_compute_o = comp_q;
    assign eng_n_o       = eng_n_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_diff_engine_scheduler.sv
// Bench for diff_engine_scheduler: timeline model of requests, grants and deliveries checked every cycle,
// plus directed scenarios with hand-computed latencies, grant order and results.
module tb_diff_engine_scheduler;

    localparam int NUM_REQ = 4;
    localparam int N_WIDTH = 6;
    localparam int F_WIDTH = 16;
    localparam int TIMEOUT = 63;

    logic                       clk = 1'b0;
    logic                       reset_ni;
    logic [NUM_REQ-1:0]         req_i;
    logic [NUM_REQ*N_WIDTH-1:0] n_i;
    logic [NUM_REQ-1:0]         grant_o;
    logic [NUM_REQ-1:0]         done_o;
    logic [F_WIDTH-1:0]         result_o;
    logic                       timeout_o;
    logic                       busy_o;
    logic                       eng_compute_o;
    logic [N_WIDTH-1:0]         eng_n_o;
    logic                       eng_done_i;
    logic [F_WIDTH-1:0]         eng_f_i;
    logic [1:0]                 state_o;

    diff_engine_scheduler #(
        .NUM_REQ(NUM_REQ), .N_WIDTH(N_WIDTH), .F_WIDTH(F_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .req_i(req_i), .n_i(n_i),
        .grant_o(grant_o), .done_o(done_o), .result_o(result_o), .timeout_o(timeout_o),
        .busy_o(busy_o), .eng_compute_o(eng_compute_o), .eng_n_o(eng_n_o),
        .eng_done_i(eng_done_i), .eng_f_i(eng_f_i), .state_o(state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- engine model ----------------
    int               eng_delay = 0;   // 0 = engine never answers
    logic [F_WIDTH-1:0] eng_val = '0;
    bit               stray_req = 1'b0;
    logic [F_WIDTH-1:0] stray_val = '0;

    initial begin
        int cd;
        cd = 0;
        eng_done_i = 1'b0;
        eng_f_i    = '0;
        forever begin
            @(negedge clk);
            eng_done_i = 1'b0;
            if (stray_req) begin
                eng_done_i = 1'b1;
                eng_f_i    = stray_val;
                stray_req  = 1'b0;
            end else if (eng_compute_o === 1'b1) begin
                cd = eng_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_done_i = 1'b1;
                    eng_f_i    = eng_val;
                end
            end
        end
    end

    // ---------------- timeline model + per-cycle compare ----------------
    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] req);
        for (int i = 1; i <= NUM_REQ; i++)
            if (req[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        return -1;
    endfunction

    bit                       m_valid = 1'b0;
    bit                       m_active = 1'b0;
    int                       m_last, m_k, m_gcyc, m_idle_from;
    logic                     s_rst, s_ed;
    logic [NUM_REQ-1:0]       s_req;
    logic [NUM_REQ*N_WIDTH-1:0] s_n;
    logic [F_WIDTH-1:0]       s_ef;
    logic [NUM_REQ-1:0]       e_grant, e_done;
    logic [F_WIDTH-1:0]       e_result;
    logic [N_WIDTH-1:0]       e_n;
    logic                     e_to, e_comp, e_busy;

    always @(posedge clk) begin
        s_rst = reset_ni; s_req = req_i; s_n = n_i; s_ed = eng_done_i; s_ef = eng_f_i;
        cyc++;
        e_grant = '0; e_done = '0; e_to = 1'b0; e_comp = 1'b0;
        if (s_rst !== 1'b1) begin
            m_valid = 1'b1; m_active = 1'b0; m_last = NUM_REQ - 1; m_idle_from = cyc;
            e_result = '0; e_n = '0;
        end else if (m_valid) begin
            if (!m_active && (cyc - 1 >= m_idle_from)) begin
                m_k = rr_pick(m_last, s_req);
                if (m_k >= 0) begin
                    e_grant[m_k] = 1'b1; e_comp = 1'b1; e_n = s_n[m_k*N_WIDTH +: N_WIDTH];
                    m_last = m_k; m_active = 1'b1; m_gcyc = cyc;
                end
            end else if (m_active && (cyc - 1 > m_gcyc)) begin
                if (s_ed === 1'b1) begin
                    e_done[m_k] = 1'b1; e_result = s_ef;
                    m_active = 1'b0; m_idle_from = cyc + 1;
                end else if (cyc - 1 == m_gcyc + TIMEOUT) begin
                    e_done[m_k] = 1'b1; e_result = '1; e_to = 1'b1;
                    m_active = 1'b0; m_idle_from = cyc + 1;
                end
            end
        end
        e_busy = m_active || (cyc < m_idle_from);
        #1;
        if (m_valid) begin
            check("grant_o", 32'(grant_o), 32'(e_grant));
            check("done_o", 32'(done_o), 32'(e_done));
            check("result_o", 32'(result_o), 32'(e_result));
            check("timeout_o", 32'(timeout_o), 32'(e_to));
            check("busy_o", 32'(busy_o), 32'(e_busy));
            check("eng_compute_o", 32'(eng_compute_o), 32'(e_comp));
            check("eng_n_o", 32'(eng_n_o), 32'(e_n));
        end
    end

    // ---------------- driver tasks ----------------
    logic [NUM_REQ-1:0] exp_q[$];

    task automatic do_reset();
        reset_ni = 1'b0;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
    endtask

    task automatic set_n(input int k, input int v);
        n_i[k*N_WIDTH +: N_WIDTH] = N_WIDTH'(v);
    endtask

    task automatic wait_grant(input int bound, output logic [NUM_REQ-1:0] g, output int at);
        g = '0; at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (grant_o != '0) begin g = grant_o; at = cyc; return; end
        end
        check("grant_wait", 32'(0), 32'(1));
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_o != '0) begin at = cyc; return; end
        end
        check("done_wait", 32'(0), 32'(1));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [NUM_REQ-1:0] g;
        int t, ga, da, prev_da, seen_done;
        reset_ni = 1'b0; req_i = '0; n_i = '0;

        // reset state
        do_reset();
        check("rst_grant", 32'(grant_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_result", 32'(result_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_eng_n", 32'(eng_n_o), 32'(0));
        check("rst_compute", 32'(eng_compute_o), 32'(0));
        check("rst_timeout", 32'(timeout_o), 32'(0));

        // single request on slot 2, engine answers after 5 cycles; a short-lived req on slot 3 is dropped
        @(negedge clk);
        set_n(2, 13); set_n(3, 21); eng_delay = 5; eng_val = 16'h1234;
        req_i = 4'b0100; t = cyc;
        wait_grant(10, g, ga);
        req_i = '0;
        check("single_grant_lat", 32'(ga - t), 32'(1));
        check("single_grant", 32'(g), 32'(4'b0100));
        check("single_eng_n", 32'(eng_n_o), 32'(13));
        @(negedge clk); req_i = 4'b1000;
        @(negedge clk);
        @(negedge clk); req_i = '0;
        wait_done(20, da);
        check("single_done_lat", 32'(da - ga), 32'(6));
        check("single_done", 32'(done_o), 32'(4'b0100));
        check("single_result", 32'(result_o), 32'(16'h1234));
        check("single_timeout", 32'(timeout_o), 32'(0));
        repeat (3) @(negedge clk);
        check("single_hold", 32'(result_o), 32'(16'h1234));
        check("dropped_req_idle", 32'(busy_o), 32'(0));

        // minimum turnaround: engine answers on the first WAIT cycle
        set_n(0, 9); eng_delay = 1; eng_val = 16'h00A5;
        req_i = 4'b0001; t = cyc;
        wait_grant(10, g, ga);
        req_i = '0;
        wait_done(10, da);
        check("min_grant_lat", 32'(ga - t), 32'(1));
        check("min_done_lat", 32'(da - t), 32'(3));
        check("min_result", 32'(result_o), 32'(16'h00A5));
        @(negedge clk);
        check("min_idle_t4", 32'(busy_o), 32'(0));

        // fairness: all four requesting from reset, order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_n(k, 10 + k);
        eng_delay = 3; eng_val = 16'h0333;
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_i = 4'b1111; prev_da = -1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(20, g, ga);
            if (i == 4) req_i = '0;
            check("rr_order", 32'(g), 32'(exp_q.pop_front()));
            if (prev_da >= 0) check("rr_gap", 32'(ga - prev_da), 32'(2));
            wait_done(20, da);
            check("rr_done", 32'(done_o), 32'(g));
            prev_da = da;
        end

        // timeout: engine silent for the whole WAIT window
        @(negedge clk);
        set_n(0, 5); eng_delay = 0;
        req_i = 4'b0001;
        wait_grant(10, g, ga);
        req_i = '0;
        wait_done(100, da);
        check("to_done_lat", 32'(da - ga), 32'(TIMEOUT + 1));
        check("to_done", 32'(done_o), 32'(4'b0001));
        check("to_result", 32'(result_o), 32'(16'hFFFF));
        check("to_flag", 32'(timeout_o), 32'(1));

        // next request after a timeout is served normally
        set_n(1, 7); eng_delay = 2; eng_val = 16'h0BEE;
        req_i = 4'b0010;
        wait_grant(10, g, ga);
        req_i = '0;
        check("post_to_grant", 32'(g), 32'(4'b0010));
        wait_done(20, da);
        check("post_to_lat", 32'(da - ga), 32'(3));
        check("post_to_result", 32'(result_o), 32'(16'h0BEE));
        check("post_to_flag", 32'(timeout_o), 32'(0));

        // completion on the terminal WAIT cycle wins
        set_n(2, 33); eng_delay = TIMEOUT; eng_val = 16'h0042;
        req_i = 4'b0100;
        wait_grant(10, g, ga);
        req_i = '0;
        wait_done(100, da);
        check("tie_lat", 32'(da - ga), 32'(TIMEOUT + 1));
        check("tie_result", 32'(result_o), 32'(16'h0042));
        check("tie_flag", 32'(timeout_o), 32'(0));

        // reset mid-WAIT; the late engine answer and a stray pulse must be ignored
        do_reset();
        set_n(0, 17); eng_delay = 10; eng_val = 16'h5555;
        req_i = 4'b0001;
        wait_grant(10, g, ga);
        req_i = '0;
        repeat (3) @(negedge clk);
        do_reset();
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 8) begin stray_val = 16'h7777; stray_req = 1'b1; end
            if (done_o != '0) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'(0));
        check("abort_result", 32'(result_o), 32'(0));
        check("abort_idle", 32'(busy_o), 32'(0));
        check("abort_state", 32'(state_o), 32'(0));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/diff_engine_scheduler.md
DIFF_ENGINE_SCHEDULER -- requirements
Module: diff_engine_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one difference engine.
REQ-002 Parameter N_WIDTH, default 6: width of the argument n.
REQ-003 Parameter F_WIDTH, default 16: width of the result f(n).
REQ-004 Parameter TIMEOUT, default 63: maximum engine wait, in cycles, before abort.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 reset_ni  input  1  reset, synchronous, active-low.
REQ-007 req_i  input  NUM_REQ  request level per requester; held until grant.
REQ-008 n_i  input  NUM_REQ*N_WIDTH  packed arguments; slice k belongs to requester k.
REQ-009 grant_o  output  NUM_REQ  one-hot, 1-cycle pulse; the requester's argument was captured.
REQ-010 done_o  output  NUM_REQ  one-hot, 1-cycle pulse; result_o is valid for that requester.
REQ-011 result_o  output  F_WIDTH  last delivered result; holds between deliveries.
REQ-012 timeout_o  output  1  1-cycle pulse, coincident with done_o, when the engine did not answer.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 eng_compute_o  output  1  1-cycle start pulse to the engine.
REQ-015 eng_n_o  output  N_WIDTH  argument to the engine; holds until next issue.
REQ-016 eng_done_i  input  1  engine completion pulse.
REQ-017 eng_f_i  input  F_WIDTH  engine result; valid when eng_done_i=1.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DELIVER; all outputs registered.
REQ-019 IDLE: if any req_i bit set at cycle t -> ISSUE at t+1; else stay IDLE.
REQ-020 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; the first set req_i bit wins.
REQ-021 ISSUE (exactly 1 cycle): grant_o[k]=1, eng_compute_o=1, eng_n_o=n_i slice k sampled at t; last_grant<=k; next state WAIT.
REQ-022 WAIT: wait counter SHALL clear on entry and increment each WAIT cycle.
REQ-023 WAIT: eng_done_i=1 -> latch eng_f_i, go to DELIVER with timeout flag 0.
REQ-024 WAIT: counter==TIMEOUT-1 and eng_done_i=0 -> go to DELIVER with timeout flag 1, i.e. abort after TIMEOUT WAIT cycles.
REQ-025 eng_done_i coinciding with terminal count SHALL take priority: real result, no timeout.
REQ-026 DELIVER (exactly 1 cycle): done_o[k]=1; result_o=latched value, or all-ones on timeout; timeout_o=flag; next state IDLE.
REQ-027 eng_done_i outside WAIT SHALL be ignored; it SHALL NOT alter result_o.
REQ-028 req_i deasserted before grant SHALL be dropped without side effects; req_i still high after done_o SHALL be re-arbitrated normally.
REQ-029 Minimum turnaround: req at t, grant at t+1, eng_done_i at t+2 gives done_o at t+3; back in IDLE at t+4.
REQ-030 Exactly one requester in flight; grant_o and done_o SHALL never have more than one bit set.

Reset
REQ-031 reset_ni=0 sampled on a clock edge SHALL force, the following cycle: state IDLE; grant_o, done_o, result_o, timeout_o, busy_o, eng_compute_o, eng_n_o, and the counter all 0; last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-032 Reset SHALL abort any in-progress transaction with no done_o; an engine completion arriving later SHALL be ignored.

Verification
REQ-033 Reset: hold reset_ni=0 for 2 cycles -> all outputs 0, busy_o=0.
REQ-034 Single request: req_i=4'b0100, n slice 2=13, engine model answers 16'h1234 after 5 cycles -> grant_o=4'b0100 and eng_n_o=13 one cycle after request; done_o=4'b0100 with result_o=16'h1234 one cycle after eng_done_i.
REQ-035 Fairness: req_i=4'b1111 held after reset, engine answers after 3 cycles -> grant order 0,1,2,3,0; no grant while busy_o=1.
REQ-036 Timeout: engine never answers, TIMEOUT=63 -> done_o pulse after 63 WAIT cycles, with result_o=16'hFFFF and timeout_o=1; next request is served normally.
REQ-037 Tie: eng_done_i arrives on WAIT cycle 63 with 16'h0042 -> result_o=16'h0042, timeout_o=0.
REQ-038 Reset mid-WAIT, then eng_done_i pulses -> no done_o, result_o stays 0, state IDLE.
